// File: rtl/strait_pe_gen.sv
// Systolic MAC processing element with shadow/active weight double buffer,
// optional two-stage psum pipeline and a sticky golden-compare fault that forces bypass.
module strait_pe_gen #(
   parameter int ACT_W      = 8,
   parameter int WGT_W      = 8,
   parameter int PSUM_W     = 24,
   parameter int MAC_STAGES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WGT_W-1:0]  weight_in,
   input  logic              weight_shift,
   input  logic              weight_commit,
   output logic [WGT_W-1:0]  weight_out,
   input  logic [ACT_W-1:0]  act_in,
   input  logic              act_valid_in,
   input  logic [PSUM_W-1:0] psum_in,
   input  logic [PSUM_W-1:0] golden_in,
   input  logic              pe_disable_in,
   input  logic              scan_en,
   input  logic              test_en,
   input  logic              fault_clear,
   output logic [ACT_W-1:0]  act_out,
   output logic              act_valid_out,
   output logic [PSUM_W-1:0] psum_out,
   output logic              psum_valid_out,
   output logic              pe_disable_out,
   output logic              fault_flag
);

   localparam int PROD_W = ACT_W + WGT_W;

   logic [WGT_W-1:0]  shadow;
   logic [WGT_W-1:0]  active;
   logic              dis_eff;
   logic              bypass;
   logic [PROD_W-1:0] prod;

   logic [PROD_W-1:0] f_prod;
   logic [PSUM_W-1:0] f_psum;
   logic [PSUM_W-1:0] f_gold;
   logic              f_byp;
   logic              f_val;
   logic [PSUM_W-1:0] sum;
   logic              mismatch;

   assign weight_out = shadow;
   assign dis_eff    = pe_disable_in | fault_flag;
   assign bypass     = scan_en | dis_eff;
   assign prod       = PROD_W'(act_in) * PROD_W'(active);

   // Commit copies the pre-shift shadow because both use the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
         active <= '0;
      end else begin
         if (weight_shift)  shadow <= weight_in;
         if (weight_commit) active <= shadow;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_out        <= '0;
         act_valid_out  <= 1'b0;
         pe_disable_out <= 1'b0;
      end else begin
         act_out        <= act_in;
         act_valid_out  <= act_valid_in;
         pe_disable_out <= dis_eff;
      end
   end

   generate
      if (MAC_STAGES == 2) begin : g_pipe
         logic [PROD_W-1:0] prod_q;
         logic [PSUM_W-1:0] psum_q;
         logic [PSUM_W-1:0] gold_q;
         logic              byp_q;
         logic              val_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               prod_q <= '0;
               psum_q <= '0;
               gold_q <= '0;
               byp_q  <= 1'b0;
               val_q  <= 1'b0;
            end else begin
               prod_q <= prod;
               psum_q <= psum_in;
               gold_q <= golden_in;
               byp_q  <= bypass;
               val_q  <= act_valid_in;
            end
         end

         assign f_prod = prod_q;
         assign f_psum = psum_q;
         assign f_gold = gold_q;
         assign f_byp  = byp_q;
         assign f_val  = val_q;
      end else begin : g_comb
         assign f_prod = prod;
         assign f_psum = psum_in;
         assign f_gold = golden_in;
         assign f_byp  = bypass;
         assign f_val  = act_valid_in;
      end
   endgenerate

   assign sum      = PSUM_W'(f_prod) + f_psum;
   assign mismatch = f_val & test_en & ~f_byp & (sum != f_gold);

   // A mismatch in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psum_out       <= '0;
         psum_valid_out <= 1'b0;
         fault_flag     <= 1'b0;
      end else begin
         psum_out       <= f_byp ? f_psum : sum;
         psum_valid_out <= f_val;
         fault_flag     <= mismatch | (fault_flag & ~fault_clear);
      end
   end

endmodule

// File: tb/tb_strait_pe_gen.sv
// Directed bench for strait_pe_gen: one-stage and two-stage instances share all stimulus.
module tb_strait_pe_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  weight_in;
   logic        weight_shift, weight_commit;
   logic [7:0]  act_in;
   logic        act_valid_in;
   logic [23:0] psum_in, golden_in;
   logic        pe_disable_in, scan_en, test_en, fault_clear;

   logic [7:0]  wo1, wo2, ao1, ao2;
   logic        av1, av2, pv1, pv2, pd1, pd2, ff1, ff2;
   logic [23:0] po1, po2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   strait_pe_gen #(.ACT_W(8), .WGT_W(8), .PSUM_W(24), .MAC_STAGES(1)) u1 (
      .clk(clk), .rst(rst), .weight_in(weight_in), .weight_shift(weight_shift),
      .weight_commit(weight_commit), .weight_out(wo1), .act_in(act_in),
      .act_valid_in(act_valid_in), .psum_in(psum_in), .golden_in(golden_in),
      .pe_disable_in(pe_disable_in), .scan_en(scan_en), .test_en(test_en),
      .fault_clear(fault_clear), .act_out(ao1), .act_valid_out(av1),
      .psum_out(po1), .psum_valid_out(pv1), .pe_disable_out(pd1), .fault_flag(ff1));

   strait_pe_gen #(.ACT_W(8), .WGT_W(8), .PSUM_W(24), .MAC_STAGES(2)) u2 (
      .clk(clk), .rst(rst), .weight_in(weight_in), .weight_shift(weight_shift),
      .weight_commit(weight_commit), .weight_out(wo2), .act_in(act_in),
      .act_valid_in(act_valid_in), .psum_in(psum_in), .golden_in(golden_in),
      .pe_disable_in(pe_disable_in), .scan_en(scan_en), .test_en(test_en),
      .fault_clear(fault_clear), .act_out(ao2), .act_valid_out(av2),
      .psum_out(po2), .psum_valid_out(pv2), .pe_disable_out(pd2), .fault_flag(ff2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_data();
      act_in = '0; act_valid_in = 1'b0; psum_in = '0; golden_in = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " u1 outs"}, {wo1, ao1, 6'b0, av1, pv1, pd1, ff1}, 32'h0);
      chk({tag, " u2 outs"}, {wo2, ao2, 6'b0, av2, pv2, pd2, ff2}, 32'h0);
      chk({tag, " u1 psum"}, {8'h0, po1}, 32'h0);
      chk({tag, " u2 psum"}, {8'h0, po2}, 32'h0);
   endtask

   // Beat i of the streaming test: act=i+1, psum=i, weight 5 up to the commit beat, 7 after.
   function automatic logic [31:0] beat_exp(input int i);
      int w;
      w = (i <= 3) ? 5 : 7;
      return 32'((i + 1) * w + i);
   endfunction

   initial begin
      // reset with every input active
      rst = 1'b1;
      weight_in = 8'hFF; weight_shift = 1'b1; weight_commit = 1'b1;
      act_in = 8'hFF; act_valid_in = 1'b1; psum_in = 24'hFFFFFF; golden_in = 24'h1;
      pe_disable_in = 1'b1; scan_en = 1'b1; test_en = 1'b1; fault_clear = 1'b0;
      step(); step(); step();
      chk_zero("reset");

      rst = 1'b0;
      weight_shift = 1'b0; weight_commit = 1'b0; weight_in = '0;
      idle_data();
      pe_disable_in = 1'b0; scan_en = 1'b0; test_en = 1'b0;
      step(); step();
      chk_zero("post reset");

      // load weight 5 and run one beat
      weight_in = 8'h05; weight_shift = 1'b1; step();
      weight_shift = 1'b0; weight_commit = 1'b1; step();
      weight_commit = 1'b0;
      chk("weight_out 5", {24'h0, wo1}, 32'h05);
      act_in = 8'd3; psum_in = 24'd10; act_valid_in = 1'b1; step();
      chk("u1 mac 25", {8'h0, po1}, 32'd25);
      chk("u1 psum valid", {31'h0, pv1}, 32'd1);
      chk("u2 act_out 3", {24'h0, ao2}, 32'd3);
      chk("u2 act_valid_out", {31'h0, av2}, 32'd1);
      chk("u2 valid not yet", {31'h0, pv2}, 32'd0);
      idle_data(); step();
      chk("u2 mac 25", {8'h0, po2}, 32'd25);
      chk("u2 psum valid", {31'h0, pv2}, 32'd1);
      chk("u1 valid drops", {31'h0, pv1}, 32'd0);

      // shift FF, then shift 0x11 with commit: active must take FF
      weight_in = 8'hFF; weight_shift = 1'b1; step();
      weight_in = 8'h11; weight_commit = 1'b1; step();
      weight_shift = 1'b0; weight_commit = 1'b0;
      chk("weight_out 11", {24'h0, wo2}, 32'h11);
      act_in = 8'hFF; psum_in = 24'hFFFFFF; act_valid_in = 1'b1; step();
      chk("u1 wrap", {8'h0, po1}, 32'h00FE00);
      idle_data(); step();
      chk("u2 wrap", {8'h0, po2}, 32'h00FE00);

      // scan bypass
      scan_en = 1'b1; act_in = 8'd3; psum_in = 24'h123456; act_valid_in = 1'b1; step();
      chk("u1 scan bypass", {8'h0, po1}, 32'h123456);
      scan_en = 1'b0; idle_data(); step();
      chk("u2 scan bypass", {8'h0, po2}, 32'h123456);

      // external disable bypass
      pe_disable_in = 1'b1; act_in = 8'd3; psum_in = 24'h123456; act_valid_in = 1'b1; step();
      chk("u1 disable bypass", {8'h0, po1}, 32'h123456);
      chk("u1 pe_disable_out", {31'h0, pd1}, 32'd1);
      pe_disable_in = 1'b0; idle_data(); step();
      chk("u2 disable bypass", {8'h0, po2}, 32'h123456);
      chk("u2 pe_disable_out low", {31'h0, pd2}, 32'd0);

      // fault: reload weight 5, golden 24 vs true 25
      weight_in = 8'h05; weight_shift = 1'b1; step();
      weight_shift = 1'b0; weight_commit = 1'b1; step();
      weight_commit = 1'b0;
      test_en = 1'b1; act_in = 8'd3; psum_in = 24'd10; golden_in = 24'd24; act_valid_in = 1'b1; step();
      chk("u1 fault set", {31'h0, ff1}, 32'd1);
      chk("u2 fault not yet", {31'h0, ff2}, 32'd0);
      idle_data(); step();
      chk("u2 fault set", {31'h0, ff2}, 32'd1);
      chk("u1 pe_disable_out fault", {31'h0, pd1}, 32'd1);
      act_in = 8'd3; psum_in = 24'h77; golden_in = 24'h5; act_valid_in = 1'b1; step();
      chk("u1 fault bypass", {8'h0, po1}, 32'h77);
      idle_data(); step();
      chk("u2 fault bypass", {8'h0, po2}, 32'h77);
      chk("u2 pe_disable_out fault", {31'h0, pd2}, 32'd1);
      fault_clear = 1'b1; step();
      fault_clear = 1'b0;
      chk("u1 fault cleared", {31'h0, ff1}, 32'd0);
      chk("u2 fault cleared", {31'h0, ff2}, 32'd0);
      act_in = 8'd3; psum_in = 24'd10; golden_in = 24'd25; act_valid_in = 1'b1; step();
      chk("u1 resumed", {8'h0, po1}, 32'd25);
      chk("u1 no fault on match", {31'h0, ff1}, 32'd0);
      idle_data(); step();
      chk("u2 resumed", {8'h0, po2}, 32'd25);
      chk("u2 no fault on match", {31'h0, ff2}, 32'd0);

      // clear coinciding with mismatch: set wins
      act_in = 8'd3; psum_in = 24'd10; golden_in = 24'd24; act_valid_in = 1'b1; fault_clear = 1'b1; step();
      chk("u1 set beats clear", {31'h0, ff1}, 32'd1);
      idle_data(); step();
      chk("u2 set beats clear", {31'h0, ff2}, 32'd1);
      chk("u1 cleared", {31'h0, ff1}, 32'd0);
      fault_clear = 1'b1; step();
      fault_clear = 1'b0; test_en = 1'b0;
      chk("u2 cleared", {31'h0, ff2}, 32'd0);
      step();

      // back-to-back beats with commit of weight 7 on beat 3
      weight_in = 8'h07; weight_shift = 1'b1; step();
      weight_shift = 1'b0;
      for (int i = 0; i < 8; i++) begin
         act_in = 8'(i + 1); psum_in = 24'(i); act_valid_in = 1'b1;
         weight_commit = (i == 3);
         step();
         chk($sformatf("u1 stream beat %0d", i), {8'h0, po1}, beat_exp(i));
         if (i > 0) chk($sformatf("u2 stream beat %0d", i - 1), {8'h0, po2}, beat_exp(i - 1));
      end
      weight_commit = 1'b0; idle_data(); step();
      chk("u2 stream beat 7", {8'h0, po2}, beat_exp(7));
      chk("u2 stream valid", {31'h0, pv2}, 32'd1);
      chk("u1 stream valid drop", {31'h0, pv1}, 32'd0);

      // reset mid-flight clears the pipeline
      act_in = 8'd2; psum_in = 24'd1; act_valid_in = 1'b1; step();
      rst = 1'b1; #1;
      chk_zero("mid reset");
      idle_data(); step();
      rst = 1'b0; step();
      chk("u2 no valid after reset", {30'h0, pv1, pv2}, 32'd0);
      chk("u2 psum after reset", {8'h0, po2}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
